// File: rtl/ice_frame_rx_pkg.sv
// Shared definitions for the ICE frame receiver: FSM state encodings,
// error codes and header byte offsets.
package ice_frame_rx_pkg;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_EID     = 3'd1;
   localparam logic [2:0] ST_LEN     = 3'd2;
   localparam logic [2:0] ST_PAYLOAD = 3'd3;
   localparam logic [2:0] ST_DRAIN   = 3'd4;

   localparam logic [1:0] ERR_TIMEOUT  = 2'd0;
   localparam logic [1:0] ERR_OVERFLOW = 2'd1;
   localparam logic [1:0] ERR_OVERRUN  = 2'd2;

   localparam int HDR_OFF_TYPE = 0;
   localparam int HDR_OFF_EID  = 1;
   localparam int HDR_OFF_LEN  = 2;
   localparam int HDR_BYTES    = 3;

endpackage

// File: rtl/ice_byte_fifo.sv
// Synchronous byte FIFO with zero read latency; pointers carry one extra
// wrap bit so full and empty are distinguishable.
module ice_byte_fifo #(
   parameter int FIFO_DEPTH = 16,
   parameter int FIFO_AW    = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       push,
   input  logic       pop,
   input  logic       flush,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic       empty,
   output logic       full
);

   localparam logic [FIFO_AW:0] PTR_ONE = {{FIFO_AW{1'b0}}, 1'b1};

   logic [7:0]       mem_q [FIFO_DEPTH];
   logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d;
   logic [FIFO_AW:0] rd_ptr_q, rd_ptr_d;
   logic             do_push_s;
   logic             do_pop_s;

   assign empty     = (wr_ptr_q == rd_ptr_q);
   assign full      = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                      (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
   assign do_pop_s  = pop && !empty;
   // A pop on a full FIFO frees the slot the simultaneous push lands in.
   assign do_push_s = push && (!full || do_pop_s);
   assign dout      = empty ? 8'h00 : mem_q[rd_ptr_q[FIFO_AW-1:0]];

   // Pointer next-state
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (do_push_s) wr_ptr_d = wr_ptr_q + PTR_ONE;
         else           wr_ptr_d = wr_ptr_q;
         if (do_pop_s)  rd_ptr_d = rd_ptr_q + PTR_ONE;
         else           rd_ptr_d = rd_ptr_q;
      end
   end

   // Pointer registers
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage write
   always_ff @(posedge clk) begin
      if (do_push_s && !flush) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= din;
   end

endmodule

// File: rtl/ice_frame_rx.sv
// ICE command frame receiver: parses [type][eid][len][payload] from the UART
// byte stream, presents the header by handshake and streams payload via FIFO.
module ice_frame_rx
   import ice_frame_rx_pkg::*;
#(
   parameter int FIFO_DEPTH  = 16,
   parameter int FIFO_AW     = 4,
   parameter int TIMEOUT_CYC = 20000,
   parameter int TO_W        = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] rx_data,
   input  logic       rx_latch,
   output logic       hdr_valid,
   input  logic       hdr_ready,
   output logic [7:0] hdr_type,
   output logic [7:0] hdr_eid,
   output logic [7:0] hdr_len,
   output logic [7:0] pl_data,
   output logic       pl_valid,
   input  logic       pl_ready,
   output logic       pl_last,
   output logic       err_valid,
   output logic [1:0] err_code,
   output logic [7:0] err_eid,
   output logic       busy
);

   localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYC);
   localparam logic [TO_W-1:0] TO_ONE   = {{(TO_W-1){1'b0}}, 1'b1};

   logic            latch_q;
   logic [2:0]      state_q, state_d;
   logic [7:0]      type_q, type_d;
   logic [7:0]      eid_q, eid_d;
   logic [7:0]      len_q, len_d;
   logic [7:0]      rem_q, rem_d;
   logic [7:0]      pop_cnt_q, pop_cnt_d;
   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
   logic            hdr_valid_q, hdr_valid_d;
   logic            err_valid_q, err_valid_d;
   logic [1:0]      err_code_q, err_code_d;
   logic [7:0]      err_eid_q, err_eid_d;

   logic            byte_s;
   logic            to_hit_s;
   logic            push_s;
   logic            flush_s;
   logic            abort_s;
   logic [1:0]      abort_code_s;
   logic            pop_fire_s;
   logic            fifo_empty_s;
   logic            fifo_full_s;
   logic [7:0]      fifo_dout_s;

   assign byte_s     = rx_latch && !latch_q;
   assign to_hit_s   = (to_cnt_q == TO_LIMIT);
   assign pop_fire_s = pl_ready && !fifo_empty_s;

   ice_byte_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .FIFO_AW    (FIFO_AW)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push_s),
      .pop   (pl_ready),
      .flush (flush_s),
      .din   (rx_data),
      .dout  (fifo_dout_s),
      .empty (fifo_empty_s),
      .full  (fifo_full_s)
   );

   // Frame FSM next-state and error detection
   always_comb begin
      state_d      = state_q;
      type_d       = type_q;
      eid_d        = eid_q;
      len_d        = len_q;
      rem_d        = rem_q;
      to_cnt_d     = to_cnt_q;
      err_valid_d  = 1'b0;
      err_code_d   = err_code_q;
      err_eid_d    = err_eid_q;
      push_s       = 1'b0;
      abort_s      = 1'b0;
      abort_code_s = ERR_TIMEOUT;
      if (pop_fire_s)                hdr_valid_d = hdr_valid_q;
      else                           hdr_valid_d = hdr_valid_q;
      if (hdr_valid_q && hdr_ready)  hdr_valid_d = 1'b0;
      else                           hdr_valid_d = hdr_valid_q;
      if (pop_fire_s)                pop_cnt_d = pop_cnt_q + 8'd1;
      else                           pop_cnt_d = pop_cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (byte_s) begin
               type_d   = rx_data;
               eid_d    = 8'h00;
               to_cnt_d = '0;
               state_d  = ST_EID;
            end else begin
               state_d  = ST_IDLE;
            end
         end
         ST_EID: begin
            if (byte_s) begin
               eid_d    = rx_data;
               to_cnt_d = '0;
               state_d  = ST_LEN;
            end else if (to_hit_s) begin
               abort_s  = 1'b1;
            end else begin
               to_cnt_d = to_cnt_q + TO_ONE;
            end
         end
         ST_LEN: begin
            if (byte_s) begin
               len_d       = rx_data;
               rem_d       = rx_data;
               hdr_valid_d = 1'b1;
               pop_cnt_d   = 8'd0;
               to_cnt_d    = '0;
               state_d     = (rx_data == 8'd0) ? ST_DRAIN : ST_PAYLOAD;
            end else if (to_hit_s) begin
               abort_s     = 1'b1;
            end else begin
               to_cnt_d    = to_cnt_q + TO_ONE;
            end
         end
         ST_PAYLOAD: begin
            if (byte_s) begin
               if (fifo_full_s && !pop_fire_s) begin
                  abort_s      = 1'b1;
                  abort_code_s = ERR_OVERFLOW;
               end else begin
                  push_s   = 1'b1;
                  rem_d    = rem_q - 8'd1;
                  to_cnt_d = '0;
                  if (rem_q == 8'd1) state_d = ST_DRAIN;
                  else               state_d = ST_PAYLOAD;
               end
            end else if (to_hit_s) begin
               abort_s  = 1'b1;
            end else begin
               to_cnt_d = to_cnt_q + TO_ONE;
            end
         end
         ST_DRAIN: begin
            // A byte here is dropped but the frame being drained carries on.
            if (byte_s) begin
               err_valid_d = 1'b1;
               err_code_d  = ERR_OVERRUN;
               err_eid_d   = eid_q;
            end else begin
               err_valid_d = 1'b0;
            end
            if (!hdr_valid_q && fifo_empty_s) state_d = ST_IDLE;
            else                              state_d = ST_DRAIN;
         end
         default: begin
            state_d     = ST_IDLE;
            hdr_valid_d = 1'b0;
         end
      endcase

      if (abort_s) begin
         err_valid_d = 1'b1;
         err_code_d  = abort_code_s;
         err_eid_d   = eid_q;
         hdr_valid_d = 1'b0;
         to_cnt_d    = '0;
         pop_cnt_d   = 8'd0;
         state_d     = ST_IDLE;
      end else begin
         err_code_d  = err_code_d;
      end
      flush_s = abort_s;
   end

   // Frame state registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         type_q      <= 8'h00;
         eid_q       <= 8'h00;
         len_q       <= 8'h00;
         rem_q       <= 8'h00;
         pop_cnt_q   <= 8'h00;
         to_cnt_q    <= '0;
         hdr_valid_q <= 1'b0;
         err_valid_q <= 1'b0;
         err_code_q  <= 2'd0;
         err_eid_q   <= 8'h00;
      end else begin
         state_q     <= state_d;
         type_q      <= type_d;
         eid_q       <= eid_d;
         len_q       <= len_d;
         rem_q       <= rem_d;
         pop_cnt_q   <= pop_cnt_d;
         to_cnt_q    <= to_cnt_d;
         hdr_valid_q <= hdr_valid_d;
         err_valid_q <= err_valid_d;
         err_code_q  <= err_code_d;
         err_eid_q   <= err_eid_d;
      end
   end

   // Latch edge history; resets high so a latch held through reset is ignored
   always_ff @(posedge clk) begin
      if (reset) latch_q <= 1'b1;
      else       latch_q <= rx_latch;
   end

   assign hdr_valid = hdr_valid_q;
   assign hdr_type  = type_q;
   assign hdr_eid   = eid_q;
   assign hdr_len   = len_q;
   assign pl_data   = fifo_dout_s;
   assign pl_valid  = !fifo_empty_s;
   assign pl_last   = !fifo_empty_s && (pop_cnt_q == (len_q - 8'd1));
   assign err_valid = err_valid_q;
   assign err_code  = err_code_q;
   assign err_eid   = err_eid_q;
   assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ice_frame_rx.sv
// Randomised self-checking bench for ice_frame_rx against a frame-level
// reference model (expected header and payload streams built from byte lists).
module tb_ice_frame_rx;
   import ice_frame_rx_pkg::*;

   localparam int TIMEOUT_CYC = 20000;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] rx_data;
   logic       rx_latch;
   logic       hdr_ready;
   logic       pl_ready;
   logic       hdr_valid, pl_valid, pl_last, err_valid, busy;
   logic [7:0] hdr_type, hdr_eid, hdr_len, pl_data, err_eid;
   logic [1:0] err_code;

   int n_cmp = 0;
   int n_bad = 0;
   bit rnd_ready = 1'b0;

   logic [7:0]  frm[$];
   logic [23:0] exp_hdr[$];
   logic [8:0]  exp_pl[$];
   logic [23:0] obs_hdr[$];
   logic [8:0]  obs_pl[$];
   logic [9:0]  obs_err[$];

   always #5 clk = ~clk;

   ice_frame_rx #(
      .FIFO_DEPTH(16), .FIFO_AW(4), .TIMEOUT_CYC(TIMEOUT_CYC), .TO_W(16)
   ) dut (
      .clk(clk), .reset(reset), .rx_data(rx_data), .rx_latch(rx_latch),
      .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .hdr_type(hdr_type),
      .hdr_eid(hdr_eid), .hdr_len(hdr_len), .pl_data(pl_data),
      .pl_valid(pl_valid), .pl_ready(pl_ready), .pl_last(pl_last),
      .err_valid(err_valid), .err_code(err_code), .err_eid(err_eid), .busy(busy)
   );

   // Record every handshake and error pulse, sampled mid-cycle
   always @(negedge clk) begin
      if (!reset) begin
         if (hdr_valid && hdr_ready) obs_hdr.push_back({hdr_type, hdr_eid, hdr_len});
         if (pl_valid && pl_ready)   obs_pl.push_back({pl_last, pl_data});
         if (err_valid)              obs_err.push_back({err_code, err_eid});
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_ready_rnd;
      if (rnd_ready) begin
         hdr_ready = ($urandom_range(0, 1) == 32'd1);
         pl_ready  = ($urandom_range(0, 3) != 32'd0);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
      rx_data  = b;
      rx_latch = 1'b1;
      for (int i = 0; i < hold; i++) begin set_ready_rnd(); tick(); end
      rx_latch = 1'b0;
      for (int i = 0; i < gap; i++) begin
         if (rnd_ready) pl_ready = 1'b1;
         tick();
      end
   endtask

   task automatic send_frame(input int hold_max);
      foreach (frm[i]) send_byte(frm[i], $urandom_range(1, hold_max), $urandom_range(1, 2));
   endtask

   // Reference model: one header, then len payload bytes with last on the final one
   task automatic model_frame;
      int len;
      len = int'(frm[HDR_OFF_LEN]);
      exp_hdr.push_back({frm[HDR_OFF_TYPE], frm[HDR_OFF_EID], frm[HDR_OFF_LEN]});
      for (int i = 0; i < len; i++) exp_pl.push_back({(i == len - 1), frm[HDR_BYTES + i]});
   endtask

   task automatic clear_q;
      exp_hdr.delete(); exp_pl.delete();
      obs_hdr.delete(); obs_pl.delete(); obs_err.delete();
   endtask

   task automatic wait_idle(input int budget, output bit ok);
      int n;
      n = 0;
      while (busy !== 1'b0 && n < budget) begin set_ready_rnd(); tick(); n++; end
      ok = (busy === 1'b0);
   endtask

   task automatic test_reset;
      reset = 1'b1; rx_latch = 1'b1; rx_data = 8'ha5; hdr_ready = 1'b0; pl_ready = 1'b0;
      repeat (3) tick();
      reset = 1'b0;
      repeat (3) tick();
      n_cmp++;
      if ({hdr_valid, pl_valid, pl_last, err_valid, busy} !== 5'b0) begin
         n_bad++;
         $display("FAIL reset_flags: got %b want 00000", {hdr_valid, pl_valid, pl_last, err_valid, busy});
      end
      n_cmp++;
      if ({hdr_type, hdr_eid, hdr_len, pl_data, err_eid, err_code} !== 42'h0) begin
         n_bad++;
         $display("FAIL reset_fields: got %h want 0", {hdr_type, hdr_eid, hdr_len, pl_data, err_eid, err_code});
      end
      rx_latch = 1'b0;
      tick();
   endtask

   task automatic test_basic;
      bit ok;
      clear_q(); hdr_ready = 1'b1; pl_ready = 1'b1;
      frm = '{8'h6d, 8'h0f, 8'h02, 8'h72, 8'h01};
      model_frame();
      send_frame(1);
      wait_idle(100, ok);
      n_cmp++;
      if (!ok || obs_hdr.size() != 1 || obs_pl.size() != 2 || obs_err.size() != 0) begin
         n_bad++;
         $display("FAIL basic_counts: got idle=%0b hdr=%0d pl=%0d err=%0d want 1/1/2/0",
                  ok, obs_hdr.size(), obs_pl.size(), obs_err.size());
      end
      for (int i = 0; i < obs_hdr.size() && i < exp_hdr.size(); i++) begin
         n_cmp++;
         if (obs_hdr[i] !== exp_hdr[i]) begin
            n_bad++; $display("FAIL basic_hdr: got %h want %h", obs_hdr[i], exp_hdr[i]);
         end
      end
      for (int i = 0; i < obs_pl.size() && i < exp_pl.size(); i++) begin
         n_cmp++;
         if (obs_pl[i] !== exp_pl[i]) begin
            n_bad++; $display("FAIL basic_pl[%0d]: got %h want %h", i, obs_pl[i], exp_pl[i]);
         end
      end
   endtask

   task automatic test_zero_len;
      int n;
      clear_q(); hdr_ready = 1'b0; pl_ready = 1'b1;
      frm = '{8'h56, 8'h00, 8'h00};
      send_frame(1);
      n = 0;
      while (hdr_valid !== 1'b1 && n < 10) begin tick(); n++; end
      for (int c = 0; c < 50; c++) begin
         n_cmp++;
         if ({hdr_valid, pl_valid, hdr_type, hdr_eid, hdr_len} !== {2'b10, 24'h560000}) begin
            n_bad++;
            $display("FAIL zero_len_hold c%0d: got v=%b pv=%b %h want v=1 pv=0 560000",
                     c, hdr_valid, pl_valid, {hdr_type, hdr_eid, hdr_len});
         end
         tick();
      end
      hdr_ready = 1'b1;
      tick();
      n_cmp++;
      if ({hdr_valid, busy} !== 2'b01) begin
         n_bad++; $display("FAIL zero_len_handshake: got v/busy=%b want 01", {hdr_valid, busy});
      end
      tick();
      n_cmp++;
      if (busy !== 1'b0 || obs_pl.size() != 0 || obs_hdr.size() != 1) begin
         n_bad++;
         $display("FAIL zero_len_idle: got busy=%b pl=%0d hdr=%0d want 0/0/1", busy, obs_pl.size(), obs_hdr.size());
      end
   endtask

   task automatic test_backpressure;
      bit ok;
      clear_q(); hdr_ready = 1'b1; pl_ready = 1'b0;
      frm = '{8'h62, 8'h0c, 8'h08, 8'hf0, 8'h12, 8'h34, 8'h50, 8'hde, 8'had, 8'hbe, 8'hef};
      model_frame();
      send_frame(2);
      repeat (2) tick();
      n_cmp++;
      if ({pl_valid, busy, pl_data} !== {2'b11, 8'hf0} || obs_pl.size() != 0) begin
         n_bad++;
         $display("FAIL bp_held: got pv=%b busy=%b data=%h pops=%0d want 1 1 f0 0",
                  pl_valid, busy, pl_data, obs_pl.size());
      end
      pl_ready = 1'b1;
      wait_idle(100, ok);
      n_cmp++;
      if (!ok || obs_pl.size() != 8) begin
         n_bad++; $display("FAIL bp_count: got idle=%0b pops=%0d want 1/8", ok, obs_pl.size());
      end
      for (int i = 0; i < obs_pl.size() && i < exp_pl.size(); i++) begin
         n_cmp++;
         if (obs_pl[i] !== exp_pl[i]) begin
            n_bad++; $display("FAIL bp_pl[%0d]: got %h want %h", i, obs_pl[i], exp_pl[i]);
         end
      end
   endtask

   task automatic test_timeout;
      int  k;
      bit  seen, ok;
      clear_q(); hdr_ready = 1'b0; pl_ready = 1'b0;
      frm = '{8'h6d, 8'h0f, 8'h02};
      send_frame(1);
      rx_data = 8'h72; rx_latch = 1'b1;
      tick();
      rx_latch = 1'b0;
      k = 0; seen = 1'b0;
      while (!seen && k < TIMEOUT_CYC + 10) begin
         tick(); k++;
         if (err_valid === 1'b1) seen = 1'b1;
      end
      n_cmp++;
      if (!seen || k < TIMEOUT_CYC || k > TIMEOUT_CYC + 2) begin
         n_bad++; $display("FAIL timeout_latency: got seen=%0b after %0d cycles want ~%0d", seen, k, TIMEOUT_CYC);
      end
      repeat (5) tick();
      n_cmp++;
      if (obs_err.size() != 1 || (obs_err.size() == 1 && obs_err[0] !== {ERR_TIMEOUT, 8'h0f})) begin
         n_bad++; $display("FAIL timeout_err: got %0d pulses first=%h want 1 pulse %h",
                           obs_err.size(), (obs_err.size() > 0) ? obs_err[0] : 10'h0, {ERR_TIMEOUT, 8'h0f});
      end
      n_cmp++;
      if ({hdr_valid, pl_valid, busy} !== 3'b000) begin
         n_bad++; $display("FAIL timeout_flush: got v/pv/busy=%b want 000", {hdr_valid, pl_valid, busy});
      end
      clear_q(); hdr_ready = 1'b1; pl_ready = 1'b1;
      frm = '{8'h6d, 8'h10, 8'h02, 8'h73, 8'h01};
      model_frame();
      send_frame(1);
      wait_idle(100, ok);
      n_cmp++;
      if (!ok || obs_hdr.size() != 1 || obs_pl.size() != 2 || obs_err.size() != 0) begin
         n_bad++; $display("FAIL timeout_next_counts: got idle=%0b hdr=%0d pl=%0d err=%0d want 1/1/2/0",
                           ok, obs_hdr.size(), obs_pl.size(), obs_err.size());
      end
      for (int i = 0; i < obs_pl.size() && i < exp_pl.size(); i++) begin
         n_cmp++;
         if (obs_pl[i] !== exp_pl[i] || obs_hdr[0] !== exp_hdr[0]) begin
            n_bad++; $display("FAIL timeout_next[%0d]: got %h/%h want %h/%h", i, obs_hdr[0], obs_pl[i], exp_hdr[0], exp_pl[i]);
         end
      end
   endtask

   task automatic test_overflow;
      clear_q(); hdr_ready = 1'b0; pl_ready = 1'b0;
      frm = '{8'h62, 8'h14, 8'h18};
      send_frame(1);
      for (int i = 1; i <= 17; i++) begin
         if (i == 17) begin
            n_cmp++;
            if (obs_err.size() != 0 || pl_valid !== 1'b1) begin
               n_bad++; $display("FAIL overflow_early: got err=%0d pv=%b before 17th byte want 0/1", obs_err.size(), pl_valid);
            end
         end
         send_byte(8'($urandom_range(0, 255)), 1, 1);
      end
      tick();
      n_cmp++;
      if (obs_err.size() != 1 || (obs_err.size() == 1 && obs_err[0] !== {ERR_OVERFLOW, 8'h14})) begin
         n_bad++; $display("FAIL overflow_err: got %0d pulses want 1 pulse %h", obs_err.size(), {ERR_OVERFLOW, 8'h14});
      end
      n_cmp++;
      if ({hdr_valid, pl_valid, busy} !== 3'b000) begin
         n_bad++; $display("FAIL overflow_state: got v/pv/busy=%b want 000", {hdr_valid, pl_valid, busy});
      end
   endtask

   task automatic test_overrun;
      bit ok;
      clear_q(); hdr_ready = 1'b0; pl_ready = 1'b1;
      frm = '{8'h41, 8'h22, 8'h01, 8'h55};
      model_frame();
      send_frame(1);
      send_byte(8'h99, 1, 2);
      n_cmp++;
      if (obs_err.size() != 1 || (obs_err.size() == 1 && obs_err[0] !== {ERR_OVERRUN, 8'h22})) begin
         n_bad++; $display("FAIL overrun_err: got %0d pulses want 1 pulse %h", obs_err.size(), {ERR_OVERRUN, 8'h22});
      end
      n_cmp++;
      if ({hdr_valid, busy, hdr_type, hdr_eid, hdr_len} !== {2'b11, 24'h412201}) begin
         n_bad++; $display("FAIL overrun_frame: got %b %h want 11 412201", {hdr_valid, busy}, {hdr_type, hdr_eid, hdr_len});
      end
      hdr_ready = 1'b1;
      wait_idle(50, ok);
      n_cmp++;
      if (!ok || obs_hdr.size() != 1 || obs_pl.size() != 1 ||
          (obs_hdr.size() == 1 && obs_hdr[0] !== exp_hdr[0]) || (obs_pl.size() == 1 && obs_pl[0] !== exp_pl[0])) begin
         n_bad++; $display("FAIL overrun_continue: got idle=%0b hdr=%0d pl=%0d want frame 412201 + 155", ok, obs_hdr.size(), obs_pl.size());
      end
   endtask

   task automatic test_latch_reset;
      bit ok;
      clear_q(); hdr_ready = 1'b1; pl_ready = 1'b1;
      frm = '{8'h33, 8'h44, 8'h01, 8'h77};
      model_frame();
      foreach (frm[i]) send_byte(frm[i], 6, 1);
      wait_idle(50, ok);
      n_cmp++;
      if (!ok || obs_hdr.size() != 1 || obs_pl.size() != 1 ||
          (obs_hdr.size() == 1 && obs_hdr[0] !== exp_hdr[0]) || (obs_pl.size() == 1 && obs_pl[0] !== exp_pl[0])) begin
         n_bad++; $display("FAIL long_latch: got idle=%0b hdr=%0d pl=%0d want one 334401 frame", ok, obs_hdr.size(), obs_pl.size());
      end
      clear_q();
      frm = '{8'h62, 8'h07, 8'h04, 8'haa, 8'hbb};
      send_frame(1);
      reset = 1'b1;
      tick();
      n_cmp++;
      if ({hdr_valid, pl_valid, pl_last, err_valid, busy, hdr_type, hdr_eid, hdr_len, pl_data, err_eid} !== 45'h0) begin
         n_bad++; $display("FAIL midframe_reset: got %h want 0",
                           {hdr_valid, pl_valid, pl_last, err_valid, busy, hdr_type, hdr_eid, hdr_len, pl_data, err_eid});
      end
      reset = 1'b0;
      repeat (4) tick();
      clear_q();
      frm = '{8'h6d, 8'h11, 8'h01, 8'h5a};
      model_frame();
      send_frame(2);
      wait_idle(50, ok);
      n_cmp++;
      if (!ok || obs_err.size() != 0 || obs_hdr.size() != 1 || obs_pl.size() != 1 ||
          (obs_hdr.size() == 1 && obs_hdr[0] !== exp_hdr[0]) || (obs_pl.size() == 1 && obs_pl[0] !== exp_pl[0])) begin
         n_bad++; $display("FAIL after_reset: got idle=%0b err=%0d hdr=%0d pl=%0d want frame 6d1101 + 15a, no err",
                           ok, obs_err.size(), obs_hdr.size(), obs_pl.size());
      end
   endtask

   task automatic test_random;
      bit ok;
      clear_q(); rnd_ready = 1'b1;
      for (int f = 0; f < 12; f++) begin
         int len;
         if (f == 0)      len = 255;
         else if (f == 1) len = 0;
         else             len = $urandom_range(0, 20);
         wait_idle(2000, ok);
         n_cmp++;
         if (!ok) begin n_bad++; $display("FAIL rnd_wait_idle f%0d: got busy=%b want 0", f, busy); end
         frm.delete();
         frm.push_back(8'($urandom_range(0, 255)));
         frm.push_back(8'($urandom_range(0, 255)));
         frm.push_back(8'(len));
         for (int i = 0; i < len; i++) frm.push_back(8'($urandom_range(0, 255)));
         model_frame();
         send_frame(3);
      end
      rnd_ready = 1'b0; hdr_ready = 1'b1; pl_ready = 1'b1;
      wait_idle(500, ok);
      n_cmp++;
      if (!ok || obs_hdr.size() != exp_hdr.size() || obs_pl.size() != exp_pl.size() || obs_err.size() != 0) begin
         n_bad++; $display("FAIL rnd_counts: got idle=%0b hdr=%0d pl=%0d err=%0d want 1/%0d/%0d/0",
                           ok, obs_hdr.size(), obs_pl.size(), obs_err.size(), exp_hdr.size(), exp_pl.size());
      end
      for (int i = 0; i < obs_hdr.size() && i < exp_hdr.size(); i++) begin
         n_cmp++;
         if (obs_hdr[i] !== exp_hdr[i]) begin
            n_bad++; $display("FAIL rnd_hdr[%0d]: got %h want %h", i, obs_hdr[i], exp_hdr[i]);
         end
      end
      for (int i = 0; i < obs_pl.size() && i < exp_pl.size(); i++) begin
         n_cmp++;
         if (obs_pl[i] !== exp_pl[i]) begin
            n_bad++; $display("FAIL rnd_pl[%0d]: got %h want %h", i, obs_pl[i], exp_pl[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero_len();
      test_backpressure();
      test_timeout();
      test_overflow();
      test_overrun();
      test_latch_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
